// File: rtl/subtractor_seq.sv
// Multi-cycle subtractor: Difference = A - B computed SLICE bits per clock with a
// rippled borrow; results and C/N/Z/V flags are registered on the completing edge.
module subtractor_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Difference,
  output logic             Bout,
  output logic             flagC,
  output logic             flagN,
  output logic             flagZ,
  output logic             flagV
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); A/B are
  // captured on that edge. done is a one-cycle pulse with busy=0, and the
  // result outputs change only on the edge that raises done.
  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [SLICE:0]   slice_diff;
  logic             last;

  // The extra top bit of slice_diff is the borrow out of the slice.
  always_comb begin
    slice_diff = {1'b0, opa[SLICE-1:0]} - {1'b0, opb[SLICE-1:0]}
               - {{SLICE{1'b0}}, borrow};
    res_next   = (res >> SLICE)
               | (WIDTH'(slice_diff[SLICE-1:0]) << (WIDTH - SLICE));
    last       = (cnt == CW'(NSL - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      opa        <= '0;
      opb        <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
      Difference <= '0;
      Bout       <= 1'b0;
      flagC      <= 1'b0;
      flagN      <= 1'b0;
      flagZ      <= 1'b0;
      flagV      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opa    <= A;
            opb    <= B;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          res    <= res_next;
          opa    <= opa >> SLICE;
          opb    <= opb >> SLICE;
          borrow <= slice_diff[SLICE];
          cnt    <= cnt + 1'b1;
          if (last) begin
            Difference <= res_next;
            Bout       <= slice_diff[SLICE];
            flagC      <= ~slice_diff[SLICE];
            flagN      <= res_next[WIDTH-1];
            flagZ      <= (res_next == '0);
            flagV      <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_subtractor_seq.sv
// Self-checking bench for subtractor_seq: directed and random subtractions
// against an arithmetic reference model, plus a single-slice instance.
module tb_subtractor_seq;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int NSL = W / S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout, fc, fn, fz, fv;
  logic [W-1:0] diff;

  logic         s_start = 1'b0;
  logic [3:0]   s_a = '0;
  logic [3:0]   s_b = '0;
  logic         s_busy, s_done, s_bout, s_fc, s_fn, s_fz, s_fv;
  logic [3:0]   s_diff;

  int             vectors = 0;
  int             checks = 0;
  int             miscompares = 0;
  logic [W+4:0]   exp_q[$];
  logic [W-1:0]   prev_diff = '0;

  always #5 clk = ~clk;

  subtractor_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Difference(diff), .Bout(bout),
    .flagC(fc), .flagN(fn), .flagZ(fz), .flagV(fv)
  );

  subtractor_seq #(.WIDTH(4), .SLICE(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .A(s_a), .B(s_b),
    .busy(s_busy), .done(s_done), .Difference(s_diff), .Bout(s_bout),
    .flagC(s_fc), .flagN(s_fn), .flagZ(s_fz), .flagV(s_fv)
  );

  // Packed expectation: {V, Z, N, C, Bout, Difference}
  function automatic logic [W+4:0] model(input int x, input int y);
    int           sx, sy, sd;
    logic [W-1:0] d;
    logic         bo, v;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    sd = sx - sy;
    d  = W'((x - y + 256) % 256);
    bo = (x < y);
    v  = (sd > 127) || (sd < -128);
    return {v, (d == '0), d[W-1], ~bo, bo, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("done_idle", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit intrude, input logic [W-1:0] ix, input logic [W-1:0] iy);
    logic [W+4:0] e;
    int           lat;
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(model(int'(x), int'(y)));
    vectors++;
    @(negedge clk);
    chk("done_drop", done, 1'b0);
    start = intrude;
    a = intrude ? ix : W'($urandom);
    b = intrude ? iy : W'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat = k;
      if (done === 1'b1) break;
      chk("busy_run", busy, 1'b1);
      chk("hold_diff", diff, prev_diff);
    end
    chk("latency", lat, NSL);
    chk("done_seen", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    e = exp_q.pop_front();
    chk("difference", diff, e[W-1:0]);
    chk("bout", bout, e[W]);
    chk("flag_c", fc, e[W+1]);
    chk("flag_n", fn, e[W+2]);
    chk("flag_z", fz, e[W+3]);
    chk("flag_v", fv, e[W+4]);
    prev_diff = e[W-1:0];
  endtask

  task automatic small_op(input logic [3:0] x, input logic [3:0] y, input logic [3:0] d,
                          input logic [4:0] f);
    s_start = 1'b1;
    s_a = x;
    s_b = y;
    vectors++;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    chk("s_done", s_done, 1'b1);
    chk("s_difference", s_diff, d);
    chk("s_flags_vznc_bout", {s_fv, s_fz, s_fn, s_fc, s_bout}, f);
    @(negedge clk);
    chk("s_done_drop", s_done, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, '0);
    chk("rst_flags", {fv, fz, fn, fc, bout}, 5'b0);
    chk("rst_small", {s_busy, s_done, s_diff, s_fv, s_fz, s_fn, s_fc, s_bout}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h0D, 8'h03, 1'b0, '0, '0); idle(1);
    run_op(8'h03, 8'h0D, 1'b0, '0, '0); idle(1);
    run_op(8'h00, 8'h00, 1'b0, '0, '0); idle(1);
    run_op(8'h80, 8'h01, 1'b0, '0, '0); idle(1);
    run_op(8'h7F, 8'hFF, 1'b0, '0, '0); idle(1);

    // A start while busy must be dropped, not queued.
    run_op(8'h02, 8'h09, 1'b1, 8'h10, 8'h01);
    idle(8);

    // Start during the done cycle.
    run_op(8'h55, 8'h22, 1'b0, '0, '0);
    run_op(8'h10, 8'h01, 1'b0, '0, '0);
    idle(1);

    // Reset in the middle of a run.
    start = 1'b1;
    a = 8'h5A;
    b = 8'h3C;
    vectors++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_diff", diff, '0);
    chk("midrst_flags", {fv, fz, fn, fc, bout}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_diff = '0;
    idle(8);
    run_op(8'hC3, 8'h3C, 1'b0, '0, '0);
    idle(1);

    repeat (40) begin
      run_op(W'($urandom), W'($urandom), 1'b0, '0, '0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    small_op(4'h2, 4'h1, 4'h1, 5'b00010);
    small_op(4'h3, 4'h5, 4'hE, 5'b00101);
    small_op(4'h8, 4'h1, 4'h7, 5'b10010);
    small_op(4'h6, 4'h6, 4'h0, 5'b01010);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/subtractor_seq.md
Name: subtractor_seq

Overview:
Parametrised multi-cycle subtractor computing Difference = A - B in SLICE-bit chunks, one chunk per clock, with a rippled borrow.
Successor of the 4-bit combinational subtractor: generic width, start/busy/done handshake, registered results, and full C/N/Z/V flags.
Used by the lab ALU datapath where a wide subtraction must not sit in a single combinational path.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥2 and a multiple of SLICE.
SLICE, 2, bits processed per clock; 1..WIDTH. NSL = WIDTH/SLICE is the number of compute cycles.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
A  in  WIDTH  minuend, sampled with accepted start
B  in  WIDTH  subtrahend, sampled with accepted start
busy  out  1  operation in progress
done  out  1  one-cycle pulse: results valid and updated
Difference  out  WIDTH  A - B mod 2^WIDTH
Bout  out  1  final borrow (1 when A < B unsigned)
flagC  out  1  carry/no-borrow = ~Bout
flagN  out  1  Difference[WIDTH-1]
flagZ  out  1  Difference == 0
flagV  out  1  signed overflow: (A[MSB]!=B[MSB]) && (Difference[MSB]!=A[MSB])

Behaviour:
- Reset (rst_n=0, async): state IDLE, busy=0, done=0, Difference=0, Bout=0, flagC=0, flagN=0, flagZ=0, flagV=0, slice counter=0, internal operand and borrow registers 0.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. When start=1 at an edge:
  - latch A and B into shift registers;
  - clear borrow and the counter;
  - go to RUN.
- RUN: busy=1. At each edge, subtract the low SLICE bits of the operand registers with the borrow-in:
  - shift the slice result into the result register from the top;
  - shift both operand registers right by SLICE;
  - update the borrow and increment the counter.
- RUN exit: on the edge processing slice NSL-1, load Difference, Bout, flagC/N/Z/V from the completed result, set done=1, go to DONE.
- DONE: lasts exactly one cycle, with done=1 and busy=0; then IDLE.
- Back-to-back: start=1 while in DONE is accepted like IDLE (go to RUN, latch new A/B), and done still drops the next cycle.
- Latency: start accepted at edge 0 → done and new results visible after edge NSL, i.e. NSL cycles.
  - busy is high after edges 1..NSL-1 and low when done is high.
  - NSL=1 (SLICE=WIDTH): done after edge 1.
- start while busy=1 is ignored, with no queuing. A/B changes during RUN have no effect.
- Output stability: Difference, Bout and all flags are written only on the completing edge. They hold their values across subsequent IDLE/RUN until the next completion; partial results are never visible.
- flagZ is computed on the full WIDTH-bit result, never on a single slice.
- flagV uses the latched operand MSBs, captured at start.
- Reset mid-operation: immediately returns to the reset state. The partial result is discarded and done is not asserted.
- Arithmetic: unsigned modulo 2^WIDTH. The borrow ripples LSB slice to MSB slice, and Bout equals the borrow out of the top slice.

Test Plan:
- WIDTH=8, SLICE=2: A=0x0D, B=0x03, start pulse → after 4 cycles done=1 for 1 cycle, Difference=0x0A, Bout=0, C=1, N=0, Z=0, V=0; busy high the 3 cycles before.
- A=0x03, B=0x0D → Difference=0xF6, Bout=1, C=0, N=1, Z=0, V=0. Then A=0x00, B=0x00 → Difference=0x00, Z=1, C=1, N=0, Bout=0.
- A=0x80, B=0x01 → Difference=0x7F, V=1, N=0, C=1; A=0x7F, B=0xFF → Difference=0x80, V=1, N=1, Bout=1.
- Ignore/back-to-back:
  - start A=0x02/B=0x09; second start A=0x10/B=0x01 while busy → result 0xF9 only, no second done.
  - start asserted during the done cycle with A=0x10/B=0x01 → next done after 4 more cycles, Difference=0x0F.
- Reset: assert rst_n=0 during RUN (slice 2) → busy=0, done=0, all outputs 0 immediately. No done after release; the next start runs a full 4 cycles.
- Instance WIDTH=4, SLICE=4: A=0x2, B=0x1 → done one cycle after start, Difference=0x1, C=1, N=0, Z=0, V=0.
